user_obi_arbiter: RTL
=====================

# user_obi_arbiter

Round-robin arbiter that shares one OBI subordinate port, such as a user-domain ROM or register block, between `NumMgr` OBI managers in the user domain. It adds zero cycles of latency. It tracks up to `MaxTrans` outstanding transactions in issue order, so each in-order response is routed back to the manager that issued the request. It sits between the user-domain crossbar outputs and a single subordinate.

## Interface
Parameters:
- `ObiCfg`, default `obi_pkg::ObiDefaultConfig`: OBI configuration shared by all ports.
- `obi_req_t`, default `logic`: OBI request struct.
- `obi_rsp_t`, default `logic`: OBI response struct.
- `NumMgr`, default 4: number of requesting managers, 2..16.
- `MaxTrans`, default 2: maximum outstanding transactions at the subordinate, 1..8.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `mgr_req_i`, input, `NumMgr` x `obi_req_t`: requests from the managers.
- `mgr_rsp_o`, output, `NumMgr` x `obi_rsp_t`: responses to the managers.
- `sbr_req_o`, output, `obi_req_t`: request to the shared subordinate.
- `sbr_rsp_i`, input, `obi_rsp_t`: response from the shared subordinate.
- `spurious_o`, output, 1: sticky flag, set when `rvalid` arrives with no transaction outstanding.

## Operation
- Eligible manager: `mgr_req_i[k].req` is high and the ID FIFO is not full.
- Arbitration is round-robin starting at pointer `rr_q`.
  - The winner's A channel (`req`, `a`) is forwarded to `sbr_req_o`.
  - When no manager is eligible, `sbr_req_o.req` is 0 and `sbr_req_o.a` is `'0`.
- Handshake: `sbr_req_o.req & sbr_rsp_i.gnt`.
  - `mgr_rsp_o[win].gnt = sbr_rsp_i.gnt`. Every other manager sees `gnt = 0`.
- Lock rule (OBI requires a stable A channel). Two states:
  - UNLOCKED to LOCKED: `req` is issued without `gnt`. The winner index is stored in `lock_idx_q`.
  - While LOCKED: the winner stays fixed until the handshake, regardless of other requests.
  - LOCKED to UNLOCKED: on the handshake.
- On each handshake:
  - The winner index is pushed into the ID FIFO (depth `MaxTrans`, width `$clog2(NumMgr)`).
  - `rr_q` becomes `(win+1) mod NumMgr`, wrapping from `NumMgr-1` to 0.
- Responses:
  - When `sbr_rsp_i.rvalid` is high, the FIFO head `h` is popped in the same cycle.
  - `mgr_rsp_o[h].r` and `rvalid` equal `sbr_rsp_i.r` and `rvalid`.
  - All other managers see `rvalid = 0` and `r = '0`.
  - `rid` passes through unchanged.
- Boundary conditions:
  - FIFO full: no manager is eligible, even if a pop occurs in the same cycle. There is no combinational pop-to-push path.
  - Push and pop in the same cycle on a non-full FIFO: the count is unchanged and the order is preserved.
  - `rvalid` while the FIFO is empty: the response is dropped to all managers and `spurious_o` is set until reset.
  - Reset asserted mid-transaction: the FIFO, lock and `rr_q` clear immediately. Responses still in flight afterwards count as spurious.

## Timing
- Reset values:
  - `rr_q = 0`, FIFO empty, state UNLOCKED, `spurious_o = 0`.
  - All `mgr_rsp_o` fields are 0.
  - `sbr_req_o` is all 0.
- Latency:
  - Grant, A-channel forwarding and response routing are combinational, so the arbiter adds zero cycles.
  - Subordinate latency is preserved end to end. With a subordinate that responds two cycles after a request, the manager sees `rvalid` two cycles after its handshake.
- The FIFO count, `rr_q`, the lock and `spurious_o` update on the rising edge of `clk_i`.
- Throughput: one handshake per cycle while the FIFO is not full.

## Configuration
- `USER_OBI_ARB_PRIO_EN` defined:
  - Manager 0 has fixed highest priority whenever it is eligible and no lock is held.
  - Managers 1..`NumMgr-1` share the remaining slots round-robin, and `rr_q` skips index 0.
- Not defined: pure round-robin across all managers.
- The lock rule applies in both modes.

## Structure
- Package `user_obi_arb_pkg`:
  - `mgr_idx_t` (width `$clog2(NumMgr)`, using the default bound).
  - The arbiter state enum `{UNLOCKED, LOCKED}`.
  - Constants `MaxNumMgr = 16` and `MaxMaxTrans = 8`.
- Sub-module `user_obi_arb_idfifo`: a synchronous FIFO of manager indices with `push`, `pop`, `full`, `empty` and `head`, and reset to empty.
- The arbitration logic lives in the top module.

## Test plan
- Single manager: mgr 2 reads address `0x0`, subordinate responds in 2 cycles with `0x01` → only `mgr_rsp_o[2]` sees `gnt` in the request cycle, then `rvalid` with `rdata = 0x01` two cycles later.
- Fairness: all 4 managers hold `req` for 8 grants → grant order 0,1,2,3,0,1,2,3, and each manager receives exactly 2 responses.
- Backpressure and lock: subordinate holds `gnt = 0` for 3 cycles while mgr 1 is selected, mgr 0 requests at cycle 1 → `sbr_req_o.a` stays mgr 1's request, mgr 1 is granted first, mgr 0 next.
- FIFO full: `MaxTrans = 2`, two grants with no response yet, third request pending → `sbr_req_o.req = 0` until the first `rvalid`; the third grant comes one cycle after that pop.
- Spurious response and reset: `rvalid` pulsed with an empty FIFO → no manager sees `rvalid` and `spurious_o = 1`. Asserting `rst_i` → `spurious_o = 0`, `rr_q = 0`.
- `USER_OBI_ARB_PRIO_EN` defined, mgr 0 and mgr 3 requesting continuously → mgr 0 wins every unlocked cycle; mgr 3 is granted only when mgr 0 drops `req`.

Source files
------------

// File: rtl/user_obi_arb_pkg.sv
// Shared types and limits for the user-domain OBI arbiter.
// Also carries a default OBI config and request/response structs so the arbiter builds standalone.
package user_obi_arb_pkg;

  localparam int unsigned MaxNumMgr   = 16;
  localparam int unsigned MaxMaxTrans = 8;

  typedef logic [$clog2(MaxNumMgr)-1:0] mgr_idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

endpackage

// File: rtl/user_obi_arb_idfifo.sv
// FIFO of manager indices recording issue order of outstanding OBI transactions.
module user_obi_arb_idfifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [CntW-1:0]  r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == CntW'(Depth));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/user_obi_arbiter.sv
// Zero-latency round-robin arbiter sharing one OBI subordinate among NumMgr managers.
// Define USER_OBI_ARB_PRIO_EN to give manager 0 fixed priority over the round-robin group.
module user_obi_arbiter
  import user_obi_arb_pkg::*;
#(
  parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
  parameter type         obi_req_t = user_obi_arb_pkg::obi_req_t,
  parameter type         obi_rsp_t = user_obi_arb_pkg::obi_rsp_t,
  parameter int unsigned NumMgr    = 4,
  parameter int unsigned MaxTrans  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  obi_req_t [NumMgr-1:0]   mgr_req_i,
  output obi_rsp_t [NumMgr-1:0]   mgr_rsp_o,
  output obi_req_t                sbr_req_o,
  input  obi_rsp_t                sbr_rsp_i,
  output logic                    spurious_o
);

  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  typedef logic [IdxW-1:0] idx_t;

  if (NumMgr < 2 || NumMgr > MaxNumMgr || MaxTrans < 1 || MaxTrans > MaxMaxTrans ||
      ObiCfg.DataWidth == 0) begin : g_param_err
    $error("user_obi_arbiter: unsupported parameterisation");
  end

  arb_state_e r_state;
  idx_t       r_rr, r_lock_idx, w_win, w_head, w_rr_nxt;
  logic       r_spurious, w_any, w_hs, w_pop, w_full, w_empty;

  // A pending-but-ungranted request pins the winner so the A channel stays stable.
  always_comb begin
    int unsigned k;
    w_win = '0;
    w_any = 1'b0;
    k     = 0;
    if (r_state == LOCKED) begin
      w_win = r_lock_idx;
      w_any = mgr_req_i[r_lock_idx].req;
    end else if (!w_full) begin
`ifdef USER_OBI_ARB_PRIO_EN
      if (mgr_req_i[0].req) begin
        w_win = '0;
        w_any = 1'b1;
      end
`endif
      for (int unsigned i = 0; i < NumMgr; i++) begin
        k = (int'(r_rr) + i) % NumMgr;
`ifdef USER_OBI_ARB_PRIO_EN
        if (!w_any && k != 0 && mgr_req_i[idx_t'(k)].req) begin
`else
        if (!w_any && mgr_req_i[idx_t'(k)].req) begin
`endif
          w_win = idx_t'(k);
          w_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_rr_nxt = (w_win == idx_t'(NumMgr - 1)) ? '0 : w_win + 1'b1;
`ifdef USER_OBI_ARB_PRIO_EN
    if (w_rr_nxt == '0) w_rr_nxt = idx_t'(1);
`endif
  end

  assign w_hs  = w_any & sbr_rsp_i.gnt;
  assign w_pop = sbr_rsp_i.rvalid & ~w_empty;

  user_obi_arb_idfifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_idfifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_hs),
    .i_data  (w_win),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= UNLOCKED;
      r_lock_idx <= '0;
      r_rr       <= '0;
      r_spurious <= 1'b0;
    end else begin
      if (w_hs) r_rr <= w_rr_nxt;
      if (sbr_rsp_i.rvalid && w_empty) r_spurious <= 1'b1;
      if (r_state == UNLOCKED) begin
        if (w_any && !sbr_rsp_i.gnt) begin
          r_state    <= LOCKED;
          r_lock_idx <= w_win;
        end
      end else if (w_hs) begin
        r_state <= UNLOCKED;
      end
    end
  end

  always_comb begin
    sbr_req_o = '0;
    mgr_rsp_o = '0;
    if (w_any) begin
      sbr_req_o.req = 1'b1;
      sbr_req_o.a   = mgr_req_i[w_win].a;
      mgr_rsp_o[w_win].gnt = sbr_rsp_i.gnt;
    end
    // Responses with nothing outstanding are dropped, never routed.
    if (w_pop) begin
      mgr_rsp_o[w_head].rvalid = 1'b1;
      mgr_rsp_o[w_head].r      = sbr_rsp_i.r;
    end
  end

  assign spurious_o = r_spurious;

endmodule
